serial_digit_adder: RTL
=======================

# serial_digit_adder

Multi-cycle, parametrised two's-complement adder/subtractor that processes `DIGIT` bits per clock through a registered carry chain. It is the width-generalised successor to the single-bit adder cells in the sequential multiplier datapath. The multiplier controller uses it as the accumulate stage: it trades latency for a short carry path at any `WIDTH`. A start/busy/done handshake frames each operation, and the block reports carry-out and signed overflow.

## Interface
- `WIDTH`, default 16: operand and result width in bits; must be a multiple of `DIGIT`.
- `DIGIT`, default 4: bits added per clock; 1 ≤ `DIGIT` ≤ `WIDTH`.
- `N` (derived localparam) = `WIDTH/DIGIT`: number of digit cycles per operation.

Ports:
- `clk` in 1: single clock; all state on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only when `busy`=0.
- `a` in `WIDTH`: operand A, captured on the accepted start.
- `b` in `WIDTH`: operand B, captured on the accepted start.
- `sub` in 1: 1 selects A−B, 0 selects A+B; captured on the accepted start.
- `cin` in 1: carry-in when adding, borrow-in when subtracting; captured on the accepted start.
- `busy` out 1: high while digit cycles run.
- `done` out 1: one-cycle pulse when the result becomes valid.
- `sum` out `WIDTH`: result; holds its value until the next accepted start completes.
- `cout` out 1: final carry (for subtraction, 1 means no borrow).
- `ovf` out 1: signed overflow, equal to the carry into the MSB XOR `cout`.

## Operation
- State machine has three states: `IDLE`, `RUN` and `DONE`.
- Start acceptance:
  - `start` is accepted when the state is `IDLE` or `DONE` (back-to-back operation is allowed).
  - `start` during `RUN` is ignored; no queuing.
- On acceptance:
  - Load shift register `ra`←`a`.
  - Load shift register `rb`←`sub ? ~b : b`.
  - Load carry register `c`←`cin ^ sub`.
  - Clear digit counter to 0 and go to `RUN`.
  - `sum`, `cout` and `ovf` keep their previous values until the new result is complete.
- `RUN`, on each edge:
  - Add `ra[DIGIT-1:0] + rb[DIGIT-1:0] + c`.
  - Shift the DIGIT-bit result into the top of the internal result register; shift `ra` and `rb` right by `DIGIT`.
  - `c` ← digit carry-out; increment the counter.
  - On the edge that processes digit `N-1`:
    - Transfer the result register to `sum`.
    - `cout`←digit carry-out; `ovf`←carry into bit `DIGIT-1` of that digit XOR its carry-out.
    - Go to `DONE`.
- `DONE`: lasts one cycle, then returns to `IDLE` unless a new `start` is accepted.
- Arithmetic: modulo 2^`WIDTH`.
  - With `sub`=1 and `cin`=0 the result is A−B; with `cin`=1 it is A−B−1.
  - With `sub`=0 the result is A+B+`cin`.
- Degenerate case `DIGIT`=`WIDTH`: a single `RUN` cycle.

## Timing
- Reset value of every output: `sum`=0, `cout`=0, `ovf`=0, `busy`=0, `done`=0. State resets to `IDLE` and the counter to 0.
- Start accepted at edge k:
  - `busy`=1 from after edge k through edge k+N.
  - `sum`, `cout` and `ovf` update at edge k+N.
  - `done`=1 for exactly the cycle following edge k+N.
- Latency from start to `done` is N cycles.
- Throughput: one operation per N+1 cycles; `start` accepted during the `DONE` cycle re-enters `RUN`.
- `busy` and `done` are registered (state decode), never both high.
- `rst` asserted mid-`RUN` aborts immediately: all outputs return to their reset values and no `done` is issued.
- Operand inputs are don't-care except in the cycle where `start` is accepted.

## Structure
- Shared package `adder_pkg` holds:
  - State encodings (`IDLE`=2'd0, `RUN`=2'd1, `DONE`=2'd2).
  - Parameter legality checks (`WIDTH % DIGIT == 0`).
- Sub-module `digit_adder #(DIGIT)`:
  - Purely combinational DIGIT-bit ripple adder built from full-adder cells.
  - Outputs: sum, carry-out and carry into the MSB (used for `ovf`).
- The top level holds the FSM, counter, shift registers and output registers.

## Test plan
All scenarios use `WIDTH`=16, `DIGIT`=4, so N=4.
- Add: `a`=0x1234, `b`=0x0FCD, `sub`=0, `cin`=0. Require `sum`=0x2201, `cout`=0, `ovf`=0, with `done` in the cycle after edge k+4.
- Unsigned wrap: 0xFFFF+0x0001 gives `sum`=0x0000, `cout`=1, `ovf`=0. Signed overflow: 0x7FFF+0x0001 gives `sum`=0x8000, `cout`=0, `ovf`=1.
- Subtract: 0x0005−0x0007 gives `sum`=0xFFFE, `cout`=0, `ovf`=0. 0x8000−0x0001 gives `sum`=0x7FFF, `cout`=1, `ovf`=1. With `cin`=1, 0x0010−0x0001 gives `sum`=0x000E.
- Start held high continuously with new operands each accept:
  - Accepts occur only in `IDLE`/`DONE` cycles, every N+1=5 cycles.
  - Operands presented during `RUN` do not disturb the result.
- Reset mid-run: `rst` pulsed 2 cycles after start. Require all outputs at 0, no `done`, and the next start completing normally.
- `DIGIT`=16, `DIGIT`=1 and `DIGIT`=8 builds: the random-operand scoreboard matches A±B exactly, with `done` latency equal to `WIDTH/DIGIT`.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and parameter checks for the serial digit adder.
// Imported by the digit cell and the top-level sequencer.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // WIDTH must split into a whole number of DIGIT-bit slices.
  function automatic bit params_ok(input int w, input int d);
    return (d >= 1) && (d <= w) && ((w % d) == 0);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells.
// Also exposes the carry into the MSB so the caller can form overflow.
module digit_adder
  import adder_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             cmsb
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co   = c[DIGIT];
  assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/serial_digit_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock via a registered carry.
// Frames each operation with start/busy/done; reports carry and overflow.
module serial_digit_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
    $error("serial_digit_adder: WIDTH must be a multiple of DIGIT");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             c;

  logic [DIGIT-1:0] ds;
  logic             dco;
  logic             dcm;
  logic [WIDTH-1:0] acc_next;

  logic accept;
  logic last;

  assign accept = start && (state != RUN);
  assign last   = (cnt == CW'(N - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a   (ra[DIGIT-1:0]),
    .b   (rb[DIGIT-1:0]),
    .ci  (c),
    .s   (ds),
    .co  (dco),
    .cmsb(dcm)
  );

  // Partial result: earlier digits shift down, newest digit enters on top.
  if (DIGIT == WIDTH) begin : g_one
    assign acc_next = ds;
  end else begin : g_multi
    logic [WIDTH-DIGIT-1:0] acc;

    assign acc_next = {ds, acc};

    // Collect completed digits while running.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc <= '0;
      end else if (state == RUN) begin
        acc <= acc_next[WIDTH-1:DIGIT];
      end
    end
  end

  // Sequencer: accept, run N digit cycles, publish result, pulse done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ra    <= '0;
      rb    <= '0;
      c     <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      ra    <= a;
      rb    <= sub ? ~b : b;
      c     <= cin ^ sub;
      cnt   <= '0;
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          ra  <= ra >> DIGIT;
          rb  <= rb >> DIGIT;
          c   <= dco;
          cnt <= cnt + 1'b1;
          if (last) begin
            sum   <= acc_next;
            cout  <= dco;
            ovf   <= dcm ^ dco;
            cnt   <= '0;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
